// File: rtl/pg_domain_sequencer_pkg.sv
// pg_pkg: shared types and defaults for the power-domain sequencer.
//   pg_state_t          - sequencer state encoding
//   PG_CNT_W_DEFAULT    - default wait-counter width
//   PG_SETTLE_DEFAULT   - default rail settle wait (cycles)
//   PG_TIMEOUT_DEFAULT  - default power-switch handshake timeout (cycles)
package pg_pkg;

    localparam int unsigned PG_CNT_W_DEFAULT   = 4;
    localparam int unsigned PG_SETTLE_DEFAULT  = 4;
    localparam int unsigned PG_TIMEOUT_DEFAULT = 12;

    typedef enum logic [3:0] {
        ST_ON,
        ST_PD_CLK,
        ST_PD_ISO,
        ST_PD_SAVE,
        ST_PD_SW,
        ST_OFF,
        ST_PU_SW,
        ST_PU_SETTLE,
        ST_PU_RESTORE,
        ST_PU_ISO,
        ST_PU_CLK
    } pg_state_t;

endpackage

// File: rtl/pg_domain_sequencer_wait_counter.sv
// pg_wait_counter: clearable saturating up-counter with a compare-to-limit
// flag, shared by the switch-handshake timeout and the rail settle wait.
//   clk     in  always-on clock
//   reset   in  async reset, active-high
//   clr_i   in  synchronous clear (counter reads 0 in the following cycle)
//   limit_i in  wait length in cycles (1..2^CNT_W-1)
//   done_o  out 1 in the last cycle of a limit_i-cycle wait
module pg_wait_counter #(
    parameter int unsigned CNT_W = pg_pkg::PG_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The counter reads 0 in the first cycle of a wait, so the limit-th
    // cycle is the one where it holds limit-1; the owner leaves on that edge.
    assign done_o = (cnt_q >= (limit_i - CNT_W'(1)));

endmodule

// File: rtl/pg_domain_sequencer.sv
// pg_domain_sequencer: always-on controller for one gated ALU power domain.
// Sequences clock gating, isolation, retention save/restore and the power
// switch handshake in a fixed safe order for power-down and power-up.
//   clk         in  always-on clock
//   reset       in  async reset, active-high (returns to ON, rail up)
//   idle_in     in  domain idle indication (level)
//   wake_req    in  wake request (level), has priority over idle_in
//   sw_ack      in  power switch status, 1 = rail up
//   sw_en       out power switch enable, 1 = rail on
//   clk_en      out domain clock enable
//   iso_en      out output isolation clamp enable
//   save        out one-cycle retention save pulse
//   restore     out one-cycle retention restore pulse
//   domain_on   out 1 only in state ON
//   busy        out 1 in any state other than ON or OFF
//   timeout_err out sticky switch-handshake timeout flag
module pg_domain_sequencer #(
    parameter int unsigned SETTLE_CYCLES = pg_pkg::PG_SETTLE_DEFAULT,
    parameter int unsigned SW_TIMEOUT    = pg_pkg::PG_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W         = pg_pkg::PG_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic idle_in,
    input  logic wake_req,
    input  logic sw_ack,
    output logic sw_en,
    output logic clk_en,
    output logic iso_en,
    output logic save,
    output logic restore,
    output logic domain_on,
    output logic busy,
    output logic timeout_err
);

    import pg_pkg::*;

    pg_state_t        state_q, state_d;
    logic             wake_pend_q, wake_pend_d;
    logic             timeout_err_q, timeout_err_d;
    logic             sw_en_q, clk_en_q, iso_en_q, save_q, restore_q;
    logic             domain_on_q, busy_q;
    logic             wait_done;
    logic             wait_clr;
    logic [CNT_W-1:0] wait_limit;

    // One counter serves both waits; only PU_SETTLE uses the settle length.
    assign wait_limit = (state_q == ST_PU_SETTLE) ? CNT_W'(SETTLE_CYCLES)
                                                  : CNT_W'(SW_TIMEOUT);
    assign wait_clr   = (state_d != state_q);

    pg_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (wait_clr),
        .limit_i (wait_limit),
        .done_o  (wait_done)
    );

    always_comb begin
        state_d       = state_q;
        wake_pend_d   = wake_pend_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_ON: begin
                if (idle_in && !wake_req) state_d = ST_PD_CLK;
            end
            ST_PD_CLK: begin
                state_d = wake_req ? ST_PU_CLK : ST_PD_ISO;
            end
            ST_PD_ISO: begin
                state_d = wake_req ? ST_PU_ISO : ST_PD_SAVE;
            end
            ST_PD_SAVE: begin
                // Rail never dropped, so an abort here skips restore.
                state_d = wake_req ? ST_PU_ISO : ST_PD_SW;
            end
            ST_PD_SW: begin
                // Committed: a wake seen now is served once the rail is down.
                if (wake_req) wake_pend_d = 1'b1;
                if (!sw_ack) begin
                    state_d = ST_OFF;
                end else if (wait_done) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_PU_SW;
                end
            end
            ST_OFF: begin
                if (wake_req || wake_pend_q) state_d = ST_PU_SW;
            end
            ST_PU_SW: begin
                if (sw_ack) begin
                    state_d = ST_PU_SETTLE;
                end else if (wait_done) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_PU_SETTLE;
                end
            end
            ST_PU_SETTLE: begin
                if (wait_done) state_d = ST_PU_RESTORE;
            end
            ST_PU_RESTORE: state_d = ST_PU_ISO;
            ST_PU_ISO:     state_d = ST_PU_CLK;
            ST_PU_CLK:     state_d = ST_ON;
            default:       state_d = ST_ON;
        endcase
        // Any entry into power-up consumes the pending wake.
        if (state_d == ST_PU_SW) wake_pend_d = 1'b0;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge that enters the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ON;
            wake_pend_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            sw_en_q       <= 1'b1;
            clk_en_q      <= 1'b1;
            iso_en_q      <= 1'b0;
            save_q        <= 1'b0;
            restore_q     <= 1'b0;
            domain_on_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wake_pend_q   <= wake_pend_d;
            timeout_err_q <= timeout_err_d;
            sw_en_q       <= !((state_d == ST_PD_SW) || (state_d == ST_OFF));
            clk_en_q      <= (state_d == ST_ON) || (state_d == ST_PU_CLK);
            iso_en_q      <= !((state_d == ST_ON)     || (state_d == ST_PD_CLK) ||
                               (state_d == ST_PU_ISO) || (state_d == ST_PU_CLK));
            save_q        <= (state_d == ST_PD_SAVE);
            restore_q     <= (state_d == ST_PU_RESTORE);
            domain_on_q   <= (state_d == ST_ON);
            busy_q        <= !((state_d == ST_ON) || (state_d == ST_OFF));
        end
    end

    assign sw_en       = sw_en_q;
    assign clk_en      = clk_en_q;
    assign iso_en      = iso_en_q;
    assign save        = save_q;
    assign restore     = restore_q;
    assign domain_on   = domain_on_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pg_domain_sequencer.sv
// Directed bench for pg_domain_sequencer. Outputs are compared as the packed
// vector {sw_en, clk_en, iso_en, save, restore, domain_on, busy, timeout_err}
// sampled 1 ns after each rising edge.
module tb_pg_domain_sequencer;

    logic clk;
    logic reset;
    logic idle_in;
    logic wake_req;
    logic sw_ack;
    logic sw_en, clk_en, iso_en, save, restore, domain_on, busy, timeout_err;
    logic [7:0] outs;

    int unsigned n_cmp;
    int unsigned n_err;
    logic        ack_follow;
    logic [7:0]  exp_q[$];

    // Expected output vectors per state, timeout_err bit clear.
    localparam logic [7:0] O_ON      = 8'b1100_0100;
    localparam logic [7:0] O_PD_CLK  = 8'b1000_0010;
    localparam logic [7:0] O_PD_ISO  = 8'b1010_0010;
    localparam logic [7:0] O_PD_SAVE = 8'b1011_0010;
    localparam logic [7:0] O_PD_SW   = 8'b0010_0010;
    localparam logic [7:0] O_OFF     = 8'b0010_0000;
    localparam logic [7:0] O_PU_SW   = 8'b1010_0010;
    localparam logic [7:0] O_SETTLE  = 8'b1010_0010;
    localparam logic [7:0] O_RESTORE = 8'b1010_1010;
    localparam logic [7:0] O_PU_ISO  = 8'b1000_0010;
    localparam logic [7:0] O_PU_CLK  = 8'b1100_0010;
    localparam logic [7:0] E         = 8'b0000_0001;

    pg_domain_sequencer #(
        .SETTLE_CYCLES (4),
        .SW_TIMEOUT    (12),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .idle_in     (idle_in),
        .wake_req    (wake_req),
        .sw_ack      (sw_ack),
        .sw_en       (sw_en),
        .clk_en      (clk_en),
        .iso_en      (iso_en),
        .save        (save),
        .restore     (restore),
        .domain_on   (domain_on),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    assign outs = {sw_en, clk_en, iso_en, save, restore, domain_on, busy, timeout_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; in follow mode the switch reports sw_en one cycle late.
    task automatic tick();
        logic prev;
        prev = sw_en;
        @(posedge clk);
        #1;
        if (ack_follow) sw_ack = prev;
    endtask

    task automatic push(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic play(input string tag);
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            tick();
            check_eq($sformatf("%s[%0d]", tag, idx), 32'(outs), 32'(exp_q.pop_front()));
            idx++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        idle_in    = 1'b0;
        wake_req   = 1'b0;
        sw_ack     = 1'b1;
        ack_follow = 1'b1;

        // Reset state, held and released with idle low.
        tick(); tick(); tick();
        check_eq("rst_outs", 32'(outs), 32'(O_ON));
        check_eq("rst_cnt", 32'(dut.u_wait.cnt_q), 32'd0);
        reset = 1'b0;
        push(O_ON, 10);
        play("hold_on");

        // Power-down: idle seen at edge 0, switch acks one cycle late.
        idle_in = 1'b1;
        push(O_PD_CLK, 1); push(O_PD_ISO, 1); push(O_PD_SAVE, 1);
        push(O_PD_SW, 2);  push(O_OFF, 3);
        play("pdown");
        idle_in = 1'b0;

        // Power-up from OFF.
        wake_req = 1'b1;
        push(O_PU_SW, 2); push(O_SETTLE, 4); push(O_RESTORE, 1);
        push(O_PU_ISO, 1); push(O_PU_CLK, 1); push(O_ON, 1);
        play("pup");
        wake_req = 1'b0;

        // Abort from PD_ISO: straight back, rail untouched, no save/restore.
        idle_in = 1'b1;
        push(O_PD_CLK, 1); push(O_PD_ISO, 1);
        play("abort_iso_a");
        wake_req = 1'b1;
        idle_in  = 1'b0;
        push(O_PU_ISO, 1); push(O_PU_CLK, 1); push(O_ON, 1);
        play("abort_iso_b");
        wake_req = 1'b0;
        push(O_ON, 1);
        play("abort_iso_c");

        // Wake during PD_SW, dropped before OFF: pending wake still powers up.
        idle_in = 1'b1;
        push(O_PD_CLK, 1); push(O_PD_ISO, 1); push(O_PD_SAVE, 1); push(O_PD_SW, 1);
        play("abort_sw_a");
        wake_req = 1'b1;
        idle_in  = 1'b0;
        push(O_PD_SW, 1);
        play("abort_sw_b");
        wake_req = 1'b0;
        push(O_OFF, 1); push(O_PU_SW, 2); push(O_SETTLE, 4); push(O_RESTORE, 1);
        push(O_PU_ISO, 1); push(O_PU_CLK, 1); push(O_ON, 1);
        play("abort_sw_c");

        // Switch stuck on: 12 cycles in PD_SW, then abort with sticky error.
        ack_follow = 1'b0;
        sw_ack     = 1'b1;
        idle_in    = 1'b1;
        push(O_PD_CLK, 1);
        play("tmo_a");
        idle_in = 1'b0;
        push(O_PD_ISO, 1); push(O_PD_SAVE, 1); push(O_PD_SW, 12);
        push(O_PU_SW | E, 1); push(O_SETTLE | E, 4); push(O_RESTORE | E, 1);
        push(O_PU_ISO | E, 1); push(O_PU_CLK | E, 1); push(O_ON | E, 3);
        play("tmo_b");

        // Reset in the middle of PU_SETTLE.
        ack_follow = 1'b1;
        idle_in    = 1'b1;
        push(O_PD_CLK | E, 1); push(O_PD_ISO | E, 1); push(O_PD_SAVE | E, 1);
        push(O_PD_SW | E, 2);  push(O_OFF | E, 1);
        play("mid_rst_a");
        idle_in  = 1'b0;
        wake_req = 1'b1;
        push(O_PU_SW | E, 2); push(O_SETTLE | E, 2);
        play("mid_rst_b");
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async", 32'(outs), 32'(O_ON));
        tick();
        check_eq("rst_next", 32'(outs), 32'(O_ON));
        check_eq("rst_next_cnt", 32'(dut.u_wait.cnt_q), 32'd0);
        reset    = 1'b0;
        wake_req = 1'b0;
        push(O_ON, 2);
        play("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
